// File: rtl/fifo_sync_pkg.sv
// ============================================================================
// fifo_sync_pkg : shared Gray/binary helpers and side-select constants for
//                 the async FIFO pointer synchronisers.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package fifo_sync_pkg;

  localparam int unsigned MODE_READ_SIDE  = 0;
  localparam int unsigned MODE_WRITE_SIDE = 1;

  // Helpers operate on a 32-bit container; width selects the active bits.
  localparam int unsigned PTR_MAX_W = 32;

  function automatic logic [31:0] width_mask(input int unsigned width);
    if (width >= PTR_MAX_W) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int unsigned width);
    logic [31:0] b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
    logic [31:0] g;
    logic [31:0] b;
    g     = gray & width_mask(width);
    b     = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pointer_sync_chain.sv
// ============================================================================
// pointer_sync_chain : multi-flop synchroniser for a Gray-coded bus,
//                      asynchronous active-high reset.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module pointer_sync_chain #(
  parameter int unsigned width       = 4,
  parameter int unsigned sync_stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] async_in,
  output logic [width-1:0] sync_out
);

  logic [width-1:0] r_stage [sync_stages];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(sync_stages); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= async_in;
      for (int i = 1; i < int'(sync_stages); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign sync_out = r_stage[sync_stages-1];

endmodule

`default_nettype wire

// File: rtl/gray_pointer_syn_block.sv
// ============================================================================
// gray_pointer_syn_block : Gray pointer synchroniser with binary conversion,
//                          update pulse, fill level and empty/full flag.
//                          Optional macro SYNC_GRAY_CHECK_EN adds a sticky
//                          multi-bit Gray-step detector on gray_error_o.
// Revision               : 1.0
// ============================================================================
`default_nettype none

module gray_pointer_syn_block
  import fifo_sync_pkg::*;
#(
  parameter int unsigned addr_size   = 3,
  parameter int unsigned sync_stages = 2,
  parameter int unsigned mode        = MODE_READ_SIDE
) (
  input  logic               dest_clock_i,
  input  logic               dest_reset_i,
  input  logic [addr_size:0] remote_gray_pointer_i,
  input  logic [addr_size:0] local_binary_pointer_i,
  output logic [addr_size:0] sync_gray_pointer_o,
  output logic [addr_size:0] sync_binary_pointer_o,
  output logic               pointer_update_o,
  output logic [addr_size:0] level_o,
  output logic               flag_o,
  output logic               gray_error_o
);

  localparam int unsigned c_ptr_w = addr_size + 1;

  generate
    if (sync_stages < 2 || sync_stages > 4) begin : g_bad_sync_stages
      $error("gray_pointer_syn_block: sync_stages must be 2..4");
    end
    if (mode > MODE_WRITE_SIDE) begin : g_bad_mode
      $error("gray_pointer_syn_block: mode must be 0 or 1");
    end
    if (addr_size < 1 || addr_size > 30) begin : g_bad_addr_size
      $error("gray_pointer_syn_block: addr_size must be 1..30");
    end
  endgenerate

  pointer_sync_chain #(
    .width       (c_ptr_w),
    .sync_stages (sync_stages)
  ) u_sync_chain (
    .clk      (dest_clock_i),
    .rst      (dest_reset_i),
    .async_in (remote_gray_pointer_i),
    .sync_out (sync_gray_pointer_o)
  );

  logic [31:0]        w_bin_wide;
  logic [c_ptr_w-1:0] w_sync_bin_next;
  logic               w_unused_bin_hi;
  logic [c_ptr_w-1:0] r_sync_bin;
  logic               r_update;

  assign w_bin_wide      = gray2bin(32'(sync_gray_pointer_o), c_ptr_w);
  assign w_sync_bin_next = w_bin_wide[c_ptr_w-1:0];
  assign w_unused_bin_hi = |w_bin_wide[31:c_ptr_w];

  // The pulse compares against the old registered value so it coincides
  // with the first cycle the new binary pointer is visible.
  always_ff @(posedge dest_clock_i or posedge dest_reset_i) begin
    if (dest_reset_i) begin
      r_sync_bin <= '0;
      r_update   <= 1'b0;
    end else begin
      r_sync_bin <= w_sync_bin_next;
      r_update   <= (w_sync_bin_next != r_sync_bin);
    end
  end

  assign sync_binary_pointer_o = r_sync_bin;
  assign pointer_update_o      = r_update;

  generate
    if (mode == MODE_WRITE_SIDE) begin : g_write_side
      assign level_o = local_binary_pointer_i - r_sync_bin;
      assign flag_o  = (local_binary_pointer_i[addr_size] != r_sync_bin[addr_size]) &&
                       (local_binary_pointer_i[addr_size-1:0] == r_sync_bin[addr_size-1:0]);
    end else begin : g_read_side
      assign level_o = r_sync_bin - local_binary_pointer_i;
      assign flag_o  = (r_sync_bin == local_binary_pointer_i);
    end
  endgenerate

`ifdef SYNC_GRAY_CHECK_EN
  logic [c_ptr_w-1:0] r_prev_gray;
  logic [c_ptr_w-1:0] w_gray_diff;
  logic               w_multi_bit;
  logic               r_gray_error;

  // More than one bit set iff clearing the lowest set bit leaves a residue.
  assign w_gray_diff = sync_gray_pointer_o ^ r_prev_gray;
  assign w_multi_bit = (w_gray_diff & (w_gray_diff - c_ptr_w'(1))) != '0;

  always_ff @(posedge dest_clock_i or posedge dest_reset_i) begin
    if (dest_reset_i) begin
      r_prev_gray  <= '0;
      r_gray_error <= 1'b0;
    end else begin
      r_prev_gray <= sync_gray_pointer_o;
      if (w_multi_bit) begin
        r_gray_error <= 1'b1;
      end
    end
  end

  assign gray_error_o = r_gray_error;
`else
  assign gray_error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_pointer_syn_block.sv
// ============================================================================
// tb_gray_pointer_syn_block : self-checking bench for gray_pointer_syn_block
//                             (read side depth 2/4, write side depth 2).
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module tb_gray_pointer_syn_block;
  import fifo_sync_pkg::*;

`ifdef SYNC_GRAY_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] remote_gray;
  logic [3:0] local_r;
  logic [3:0] local_w;

  logic [3:0] sg2, sb2, lv2, sg4, sb4, lv4, sgw, sbw, lvw;
  logic       up2, fl2, ge2, up4, fl4, ge4, upw, flw, gew;

  gray_pointer_syn_block #(.addr_size(3), .sync_stages(2), .mode(MODE_READ_SIDE)) dut_rd2 (
    .dest_clock_i(clk), .dest_reset_i(rst),
    .remote_gray_pointer_i(remote_gray), .local_binary_pointer_i(local_r),
    .sync_gray_pointer_o(sg2), .sync_binary_pointer_o(sb2), .pointer_update_o(up2),
    .level_o(lv2), .flag_o(fl2), .gray_error_o(ge2));

  gray_pointer_syn_block #(.addr_size(3), .sync_stages(4), .mode(MODE_READ_SIDE)) dut_rd4 (
    .dest_clock_i(clk), .dest_reset_i(rst),
    .remote_gray_pointer_i(remote_gray), .local_binary_pointer_i(local_r),
    .sync_gray_pointer_o(sg4), .sync_binary_pointer_o(sb4), .pointer_update_o(up4),
    .level_o(lv4), .flag_o(fl4), .gray_error_o(ge4));

  gray_pointer_syn_block #(.addr_size(3), .sync_stages(2), .mode(MODE_WRITE_SIDE)) dut_wr2 (
    .dest_clock_i(clk), .dest_reset_i(rst),
    .remote_gray_pointer_i(remote_gray), .local_binary_pointer_i(local_w),
    .sync_gray_pointer_o(sgw), .sync_binary_pointer_o(sbw), .pointer_update_o(upw),
    .level_o(lvw), .flag_o(flw), .gray_error_o(gew));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_fail;
  logic [3:0] rem_bin;
  logic [3:0] hist[$];   // remote binary value present at each edge since reset

  typedef struct {
    logic [3:0] rem;
    logic [3:0] loc;
    logic [3:0] lv_rd;
    logic       fl_rd;
    logic [3:0] lv_wr;
    logic       fl_wr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] g4(input logic [3:0] b);
    logic [31:0] t;
    t = bin2gray({28'd0, b}, 4);
    return t[3:0];
  endfunction

  task automatic set_remote(input logic [3:0] b);
    rem_bin     = b;
    remote_gray = g4(b);
  endtask

  task automatic step();
    hist.push_back(rem_bin);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] hist_at(input int idx);
    if (idx < 0) return 4'd0;
    return hist[idx];
  endfunction

  // Reference: a value sampled at edge k is the Gray output after edge
  // k+S-1 and the binary output one edge later.
  function automatic logic [3:0] exp_gray(input int s);
    return g4(hist_at(hist.size() - s));
  endfunction
  function automatic logic [3:0] exp_bin(input int s);
    return hist_at(hist.size() - s - 1);
  endfunction
  function automatic logic exp_upd(input int s);
    return hist_at(hist.size() - s - 1) != hist_at(hist.size() - s - 2);
  endfunction

  task automatic check_model();
    logic [3:0] occ;
    check("rd2_gray", sg2, exp_gray(2));
    check("rd2_bin",  sb2, exp_bin(2));
    check("rd2_upd",  up2, exp_upd(2));
    occ = exp_bin(2) - local_r;
    check("rd2_level", lv2, occ);
    check("rd2_empty", fl2, occ == 4'd0);
    check("rd4_gray", sg4, exp_gray(4));
    check("rd4_bin",  sb4, exp_bin(4));
    check("rd4_upd",  up4, exp_upd(4));
    occ = exp_bin(4) - local_r;
    check("rd4_level", lv4, occ);
    check("rd4_empty", fl4, occ == 4'd0);
    check("wr2_gray", sgw, exp_gray(2));
    check("wr2_bin",  sbw, exp_bin(2));
    check("wr2_upd",  upw, exp_upd(2));
    occ = local_w - exp_bin(2);
    check("wr2_level", lvw, occ);
    check("wr2_full",  flw, occ == 4'd8);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hist.delete();
  endtask

  vec_t vecs[7];

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    local_r = 4'd0;
    local_w = 4'd0;
    set_remote(4'd0);

    vecs[0] = '{rem: 4'd0,  loc: 4'd0,  lv_rd: 4'd0, fl_rd: 1'b1, lv_wr: 4'd0,  fl_wr: 1'b0};
    vecs[1] = '{rem: 4'd0,  loc: 4'd7,  lv_rd: 4'd9, fl_rd: 1'b0, lv_wr: 4'd7,  fl_wr: 1'b0};
    vecs[2] = '{rem: 4'd0,  loc: 4'd8,  lv_rd: 4'd8, fl_rd: 1'b0, lv_wr: 4'd8,  fl_wr: 1'b1};
    vecs[3] = '{rem: 4'd5,  loc: 4'd2,  lv_rd: 4'd3, fl_rd: 1'b0, lv_wr: 4'd13, fl_wr: 1'b0};
    vecs[4] = '{rem: 4'd1,  loc: 4'd14, lv_rd: 4'd3, fl_rd: 1'b0, lv_wr: 4'd13, fl_wr: 1'b0};
    vecs[5] = '{rem: 4'd14, loc: 4'd6,  lv_rd: 4'd8, fl_rd: 1'b0, lv_wr: 4'd8,  fl_wr: 1'b1};
    vecs[6] = '{rem: 4'd9,  loc: 4'd9,  lv_rd: 4'd0, fl_rd: 1'b1, lv_wr: 4'd0,  fl_wr: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_gray", sg2, 0);
    check("reset_bin",  sb2, 0);
    check("reset_upd",  up2, 0);
    check("reset_err",  ge2, 0);
    check("reset_level", lv2, 0);
    check("reset_empty", fl2, 1);
    check("reset_full",  flw, 0);
    rst = 1'b0;
    hist.delete();

    // Latency: remote 0 -> 1 ahead of edge 1.
    set_remote(4'd1);
    step();
    check("lat_e1_gray2", sg2, 0);
    step();
    check("lat_e2_gray2", sg2, 4'b0001);
    check("lat_e2_bin2",  sb2, 0);
    check("lat_e2_upd2",  up2, 0);
    step();
    check("lat_e3_bin2",  sb2, 1);
    check("lat_e3_upd2",  up2, 1);
    check("lat_e3_lvl2",  lv2, 1);
    check("lat_e3_flag2", fl2, 0);
    check("lat_e3_gray4", sg4, 0);
    step();
    check("lat_e4_upd2",  up2, 0);
    check("lat_e4_gray4", sg4, 4'b0001);
    check("lat_e4_bin4",  sb4, 0);
    step();
    check("lat_e5_bin4",  sb4, 1);
    check("lat_e5_upd4",  up4, 1);
    step();
    check("lat_e6_upd4",  up4, 0);

    // Asynchronous reset mid-stream, then re-acquisition latency.
    set_remote(4'd4);
    repeat (4) step();
    check("pre_rst_gray2", sg2, 4'b0110);
    #3 rst = 1'b1;
    #1;
    check("arst_gray2",  sg2, 0);
    check("arst_bin2",   sb2, 0);
    check("arst_upd2",   up2, 0);
    check("arst_level2", lv2, 0);
    check("arst_empty2", fl2, 1);
    check("arst_err2",   ge2, 0);
    check("arst_gray4",  sg4, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    hist.delete();
    step();
    check("reacq_e1_gray2", sg2, 0);
    check_model();
    step();
    check("reacq_e2_gray2", sg2, 4'b0110);
    check_model();

    // Table: combinational level/flag against a settled remote pointer.
    foreach (vecs[i]) begin
      set_remote(vecs[i].rem);
      repeat (4) step();
      local_r = vecs[i].loc;
      local_w = vecs[i].loc;
      #1;
      check($sformatf("tbl%0d_lvl_rd", i),  lv2, vecs[i].lv_rd);
      check($sformatf("tbl%0d_flag_rd", i), fl2, vecs[i].fl_rd);
      check($sformatf("tbl%0d_lvl_wr", i),  lvw, vecs[i].lv_wr);
      check($sformatf("tbl%0d_flag_wr", i), flw, vecs[i].fl_wr);
    end

    // Write side: local increment to full shows up without a clock edge.
    local_w = 4'd7;
    set_remote(4'd0);
    repeat (4) step();
    check("full_pre", flw, 0);
    local_w = 4'd8;
    #1;
    check("full_same_cycle", flw, 1);
    check("full_level", lvw, 8);

    // Wrap: remote walks up to 14, then 15 -> 0 -> 1 with local at 14.
    do_reset();
    local_r = 4'd14;
    local_w = 4'd0;
    set_remote(4'd0);
    for (int b = 0; b <= 14; b++) begin
      set_remote(4'(b));
      step();
      check_model();
    end
    for (int k = 0; k < 3; k++) begin
      set_remote(4'(15 + k));
      repeat (3) begin
        step();
        check_model();
      end
      check($sformatf("wrap%0d_level", k), lv2, 4'(k + 1));
      check($sformatf("wrap%0d_empty", k), fl2, 0);
    end

    // Gray-step violation: 0000 -> 0011, then a legal step, then reset.
    do_reset();
    set_remote(4'd0);
    step();
    set_remote(4'd2);
    repeat (5) step();
    check("gerr_set2", ge2, CHK);
    check("gerr_set4", ge4, CHK);
    set_remote(4'd3);
    repeat (6) step();
    check("gerr_hold2", ge2, CHK);
    check("gerr_hold4", ge4, CHK);
    #2 rst = 1'b1;
    #1;
    check("gerr_clr2", ge2, 0);
    check("gerr_clr4", ge4, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    hist.delete();

    // Randomised legal Gray traffic against the reference model.
    set_remote(4'd0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) set_remote(rem_bin + 4'd1);
      local_r = 4'($urandom_range(0, 15));
      local_w = 4'($urandom_range(0, 15));
      step();
      check_model();
      check("rand_gerr", ge2 | ge4 | gew, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_pointer_syn_block.md
Name: gray_pointer_syn_block

Overview:
Parametrised successor to the 2-flop pointer synchroniser used in the async FIFO. It carries a Gray-coded pointer from the remote clock domain through a configurable-depth flop chain into the local domain. It then converts the result to binary, pulses on every pointer update, and derives a fill level and an empty or full flag against the local binary pointer. One instance sits on each side of the async FIFO: the read side produces empty, the write side produces full.

Parameters:
addr_size, 3, FIFO address width; pointers are addr_size+1 bits (extra wrap bit)
sync_stages, 2, synchroniser flop count; legal 2..4, elaboration error otherwise
mode, 0, 0 = read side (remote = write ptr, flag = empty); 1 = write side (remote = read ptr, flag = full)

Ports:
dest_clock_i  in  1  local-domain clock
dest_reset_i  in  1  asynchronous, active-high reset
remote_gray_pointer_i  in  addr_size+1  Gray pointer from remote domain (asynchronous to dest_clock_i)
local_binary_pointer_i  in  addr_size+1  local side's own binary pointer, dest-domain
sync_gray_pointer_o  out  addr_size+1  last stage of sync chain
sync_binary_pointer_o  out  addr_size+1  registered Gray-to-binary of sync_gray_pointer_o
pointer_update_o  out  1  one-cycle pulse when the synced pointer changed
level_o  out  addr_size+1  occupancy, 0..2^addr_size
flag_o  out  1  empty (mode 0) / full (mode 1)
gray_error_o  out  1  sticky Gray-step violation (see Optional Feature)

Behaviour:
- Reset (async assert, sync-safe deassert assumed upstream): every flop cleared to 0. Outputs in reset:
  - sync_gray_pointer_o = 0, sync_binary_pointer_o = 0, pointer_update_o = 0, gray_error_o = 0.
  - level_o and flag_o follow their combinational equations below, with the synced pointer at 0.
- Sync chain: stage0 <= remote_gray_pointer_i; stage[i] <= stage[i-1]; sync_gray_pointer_o = stage[sync_stages-1].
  - A remote value sampled at edge k appears at the output after edge k+sync_stages-1.
- Binary stage: sync_binary_pointer_o <= gray2bin(sync_gray_pointer_o), one edge after the Gray output.
  - gray2bin: b[msb] = g[msb]; b[i] = b[i+1] ^ g[i].
- pointer_update_o <= (gray2bin(sync_gray_pointer_o) != sync_binary_pointer_o). It is high for exactly the cycle in which the new binary value is first visible, and stays high for consecutive cycles if the pointer changes every cycle.
- level_o and flag_o are combinational from sync_binary_pointer_o and local_binary_pointer_i. There is no added latency versus the local pointer, so a local increment is reflected in the same cycle.
  - mode 0: level_o = sync_bin - local_bin (mod 2^(addr_size+1)); flag_o = (sync_bin == local_bin).
  - mode 1: level_o = local_bin - sync_bin (mod 2^(addr_size+1)); flag_o = MSBs differ AND lower addr_size bits equal.
- Wrap-around: pointers wrap modulo 2^(addr_size+1). The modular subtraction yields the correct level across wrap; no special-casing.
- Flags are pessimistic by design, because the remote pointer is seen late:
  - empty may be held longer than true;
  - full may be held longer than true;
  - neither is ever released early.
- Reset mid-operation clears the chain immediately; the in-flight remote value is discarded and re-acquired after reset release with full chain latency.

Optional Feature:
Macro SYNC_GRAY_CHECK_EN.
- Defined: an extra register holds the previous sync_gray_pointer_o. gray_error_o is set when consecutive values differ in more than one bit, and stays set until dest_reset_i. A change of exactly one bit, or no change, is legal.
- Undefined: the check logic is absent and gray_error_o is tied to 0. The port list is identical either way.

Decomposition:
- Package fifo_sync_pkg holds:
  - gray2bin and bin2gray functions, parametrised by width (bin2gray is used by the bench);
  - constants MODE_READ_SIDE = 0 and MODE_WRITE_SIDE = 1.
- Sub-module pointer_sync_chain (width, sync_stages): the pure flop chain with async active-high reset. The top adds the binary stage, update pulse, level/flag logic and the optional check.

Test Plan:
- Reset (mode 0, sync_stages=2): reset asserted mid-stream with remote=0110 -> all regs 0 asynchronously, level_o=0, flag_o=1 (local=0).
- Latency (mode 0, sync_stages=2): remote 0000->0001 before edge 1 -> sync_gray=0001 after edge 2; sync_bin=0001, pointer_update_o=1 for one cycle after edge 3, level_o=1, flag_o=0.
- Depth 4: same stimulus with sync_stages=4 -> sync_gray after edge 4, binary/pulse after edge 5.
- Wrap (mode 0, addr_size=3): remote steps bin 14->15->0->1 (Gray), local=14 -> level_o = 1, 2, 3 in turn, flag_o=0 throughout.
- Full (mode 1): sync_bin=0000, local=1000 -> flag_o=1, level_o=8. local=0111 -> flag_o=0, level_o=7. Incrementing local to 1000 raises flag_o in the same cycle.
- SYNC_GRAY_CHECK_EN: remote jumps 0000->0011 -> gray_error_o=1 after it reaches the sync output, and stays 1 through later legal steps until reset. Without the macro, gray_error_o stays 0.
